mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port program/data RAM among NUM_PORTS requesters of the 8-bit processor.
//  Port 0 is instruction fetch; ports 1..3 are data, reserve and spare.
//  Arbitrates with req/ack, sequences each access through a fixed-latency RAM, and returns read data.
//  Sits between the processor core and the RAM macro, and replaces ad-hoc per-port enable/ready wiring.
// PARAMETERS
//  NUM_PORTS  4  number of requesters (2..4)
//  ADDR_W     7  RAM address width
//  DATA_W     8  RAM data width
//  MEM_LAT    1  cycles from mem_en to valid mem_rdata (1..15)
// PORTS
//  clk        in   1                  system clock; all logic on posedge
//  rst_n      in   1                  synchronous reset, active-low
//  req        in   NUM_PORTS          per-port request; held with operands until ack
//  we         in   NUM_PORTS          per-port write enable (1=write, 0=read)
//  addr       in   NUM_PORTS*ADDR_W   per-port address, port p at [p*ADDR_W +: ADDR_W]
//  wdata      in   NUM_PORTS*DATA_W   per-port write data, same packing
//  ack        out  NUM_PORTS          one-hot, one-cycle completion pulse
//  rdata      out  DATA_W             shared read data, valid in the ack cycle of a read
//  grant      out  NUM_PORTS          one-hot owner, non-zero from ACCESS through RESP
//  busy       out  1                  high whenever state != IDLE
//  mem_en     out  1                  RAM access strobe, one cycle per transaction
//  mem_we     out  1                  RAM write enable, qualified by mem_en
//  mem_addr   out  ADDR_W             RAM address
//  mem_wdata  out  DATA_W             RAM write data
//  mem_rdata  in   DATA_W             RAM read data
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; ack, grant, busy, mem_en, mem_we = 0; rdata, mem_addr, mem_wdata = 0.
//   RR pointer is set so that port 0 has the highest priority next.
//  FSM: IDLE -> ACCESS -> WAIT -> RESP -> IDLE. Every output is registered.
//   IDLE: if any req, pick the winner and latch its we/addr/wdata into the mem_* regs; go to ACCESS. Otherwise stay.
//   ACCESS: 1 cycle; mem_en=1; load wait counter with MEM_LAT-1; go to WAIT.
//   WAIT: MEM_LAT cycles, counting down to 0. On the last cycle capture mem_rdata into rdata (reads only). Go to RESP.
//   RESP: 1 cycle; ack[winner]=1; advance the RR pointer to winner+1 mod NUM_PORTS; go to IDLE.
//  Latency: req sampled in IDLE cycle T0 -> ack in cycle T0+MEM_LAT+2. Throughput is 1 access per MEM_LAT+3 cycles.
//  Arbitration is round-robin from the RR pointer. A continuously requesting port is served at most once per rotation when others wait.
//  A requester drops req (or presents its next op) at the posedge after seeing ack. IDLE evaluates req only after RESP.
//  req dropped mid-transaction: the access still completes and ack still pulses. The bus is not aborted.
//  Write: rdata holds its previous value; ack timing is identical to a read.
//  Operand changes after the IDLE grant cycle are ignored. The latched values are used.
//  Reset asserted mid-transaction: immediate return to IDLE with outputs at reset values. No ack for the aborted access.
//  Out-of-range port indices (p >= NUM_PORTS) do not exist; unused high bits are ignored.
// CONFIGURATION
//  MEM_ARB_FETCH_PRIORITY_EN defined: port 0 (fetch) wins whenever req[0]=1 in IDLE.
//   Ports 1..N-1 rotate round-robin among themselves, and the RR pointer skips port 0.
//  Undefined: all ports, including port 0, take part in plain round-robin.
// STRUCTURE
//  Package mem_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3).
//   Also holds default widths (ADDR_W=7, DATA_W=8) and the port index constants FETCH=0, DATA=1, RESERVE=2, SPARE=3.
//  Sub-module rr_pick: combinational rotate-priority picker.
//   Inputs: req vector and pointer. Outputs: one-hot winner and its index.
//   Shared by the normal and fetch-priority paths.
// TESTING
//  1. Reset: hold rst_n=0 for 2 cycles, with req=4'b1111 during reset -> ack=0, grant=0, mem_en=0, busy=0 throughout.
//  2. Single read: port 1 requests addr=7'd32, RAM holds 8'hA5 there, MEM_LAT=1.
//     -> mem_en is high exactly once, in cycle T0+1, with mem_addr=32; ack=4'b0010 in T0+3 with rdata=8'hA5.
//  3. Write then read-back: port 2 writes 8'h3C to addr 7'd5, then reads addr 5.
//     -> mem_we=1 with mem_en on the write; the read ack returns rdata=8'h3C; rdata is unchanged in the write ack cycle.
//  4. Contention: req=4'b1111 held, each port re-requesting after its ack.
//     -> acks in order port 0,1,2,3,0. With MEM_ARB_FETCH_PRIORITY_EN defined: 0,0,0... while req[0]=1.
//     -> With that macro, after req[0]=0 the others are served 1,2,3.
//  5. Reset mid-op: MEM_LAT=4, drop rst_n in the second WAIT cycle.
//     -> no ack ever for that access; state is IDLE; the next grant goes to port 0.
//  6. Abandoned req: port 3 drops req the cycle after ACCESS -> ack[3] still pulses at T0+MEM_LAT+2; no re-grant follows.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM encoding, default widths and port roles for mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam int ARB_ADDR_W = 7;
  localparam int ARB_DATA_W = 8;
  localparam int CNT_W      = 4;   // holds MEM_LAT-1 for MEM_LAT up to 15

  // Port roles on the processor side.
  localparam int FETCH   = 0;
  localparam int DATA    = 1;
  localparam int RESERVE = 2;
  localparam int SPARE   = 3;

  // Width of a port index; never zero, even for a single port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority picker. The port at ptr has the
// highest priority, then ptr+1, wrapping around to the ports below ptr.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] upper;
  logic [N-1:0] cand;

  // Prefer requesters at or above ptr; fall back to the lowest requester overall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    upper = '0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      upper[k] = req[k] && (k >= int'(ptr));
    end
    cand = (|upper) ? upper : req;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port RAM among NUM_PORTS
// requesters with a req/ack handshake. Optional build macro:
//   MEM_ARB_FETCH_PRIORITY_EN - port 0 (fetch) always wins when requesting;
//                               the other ports rotate among themselves.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        busy,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d, ptr_adv;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d, grant_q, grant_d;
  logic                   busy_q, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;

  logic [NUM_PORTS-1:0]   rr_req, rr_gnt, win_gnt;
  logic [IDX_W-1:0]       rr_idx, win_idx;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  rr_pick #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
    .req (rr_req),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

`ifdef MEM_ARB_FETCH_PRIORITY_EN
  // Fetch is kept out of the rotation; it overrides the picker when requesting.
  assign rr_req = req & ~NUM_PORTS'(1);

  // Fetch override on top of the round-robin result among the other ports.
  always_comb begin
    win_gnt = rr_gnt;
    win_idx = rr_idx;
    if (req[FETCH]) begin
      win_gnt        = '0;
      win_gnt[FETCH] = 1'b1;
      win_idx        = IDX_W'(FETCH);
    end
  end
`else
  assign rr_req  = req;
  assign win_gnt = rr_gnt;
  assign win_idx = rr_idx;
`endif

  // Operand mux: select the winning port's we/addr/wdata.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (win_idx == IDX_W'(k)) begin
        sel_we    = we[k];
        sel_addr  = addr[k*ADDR_W +: ADDR_W];
        sel_wdata = wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Pointer after service: the port following the winner gets top priority.
  always_comb begin
    ptr_adv = (win_q == IDX_W'(NUM_PORTS - 1)) ? '0 : win_q + IDX_W'(1);
`ifdef MEM_ARB_FETCH_PRIORITY_EN
    if (ptr_adv == IDX_W'(FETCH)) ptr_adv = IDX_W'(1);
`endif
  end

  // Next-state and next-output logic; every output is then registered.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    grant_d     = grant_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = ACCESS;
          win_d       = win_idx;
          grant_d     = win_gnt;
          mem_en_d    = 1'b1;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end
      end
      ACCESS: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          ack_d   = grant_q;
          if (!mem_we_q) rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = ptr_adv;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(FETCH);
      win_q       <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      grant_q     <= grant_d;
      busy_q      <= (state_d != IDLE);
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
